lap_memory: RTL and testbench
=============================

LAP_MEMORY -- requirements
Module: lap_memory

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have port RST, input, 1, asynchronous active-low reset; RST=0 forces reset state immediately, release is sampled on CLK.
REQ-003 SHALL have port EN100HZ, input, 1, one-cycle 10 ms tick from the stopwatch timebase.
REQ-004 SHALL have port RUN, input, 1, level, 1 = stopwatch counting.
REQ-005 SHALL have port LAP, input, 1, one-cycle debounced lap-button pulse.
REQ-006 SHALL have port RECALL, input, 1, one-cycle debounced recall-button pulse.
REQ-007 SHALL have port CLR, input, 1, one-cycle clear pulse, the same pulse that clears the stopwatch counters.
REQ-008 SHALL have port DIN, input, 24, live BCD time {min10,min1,sec10,sec1,msec100,msec10}, 4 bits each, min10 in MSBs.
REQ-009 SHALL have port DOUT, output, 24, BCD time to the 7-segment decoders, same packing as DIN.
REQ-010 SHALL have port LAPNO, output, 3, lap index shown (0 = live).
REQ-011 SHALL have port FULL, output, 1, 1 when all 4 slots hold valid laps.
REQ-012 SHALL have port MODE, output, 2, current state: 00 LIVE, 01 SPLIT, 10 RECALL.

Function
REQ-013 SHALL store up to 4 laps of 24 bits each in a circular buffer, with write pointer WP (2 bits) and count CNT (0..4).
REQ-014 SHALL register DOUT, LAPNO and MODE: each changes on the clock edge after the event that causes it, a latency of 1 cycle.
REQ-015 In LIVE, SHALL drive DOUT = DIN delayed by 1 cycle and LAPNO = 0.
REQ-016 LAP with RUN=1, in any state, SHALL write DIN to slot WP, set WP=WP+1 mod 4, set CNT=min(CNT+1,4), load hold timer = 199, and enter SPLIT.
REQ-017 LAP with RUN=0 SHALL be ignored.
REQ-018 When CNT=4, a capture SHALL overwrite the oldest slot; CNT stays 4 and FULL stays 1.
REQ-019 In SPLIT, DOUT SHALL hold the captured value and LAPNO SHALL equal the post-capture CNT (1..4).
REQ-020 In SPLIT, the hold timer SHALL decrement on each EN100HZ; on EN100HZ with timer=0, the block SHALL return to LIVE, giving a 200-tick (2.00 s) hold.
REQ-021 In SPLIT, a new LAP SHALL recapture and restart the timer; RECALL SHALL be ignored.
REQ-022 RECALL in LIVE with CNT>0 SHALL enter RECALL with read index RI = 0, the oldest slot, at physical slot (WP-CNT) mod 4.
REQ-023 RECALL in LIVE with CNT=0 SHALL be ignored.
REQ-024 In RECALL, DOUT SHALL show slot (WP-CNT+RI) mod 4 and LAPNO = RI+1.
REQ-025 In RECALL, a further RECALL SHALL increment RI; RECALL when RI = CNT-1 SHALL return to LIVE.
REQ-026 RECALL state SHALL not time out.
REQ-027 Priority SHALL be CLR > LAP > RECALL when pulses coincide in the same cycle.
REQ-028 CLR in any state SHALL set CNT=0, WP=0, RI=0, FULL=0 and enter LIVE; slot contents need not be zeroed but SHALL be unreadable.
REQ-029 FULL SHALL be registered and equal (CNT==4).

Reset
REQ-030 RST=0 SHALL asynchronously force MODE=00, DOUT=24'h000000, LAPNO=0, FULL=0, CNT=0, WP=0, RI=0 and hold timer = 0.
REQ-031 Reset asserted mid-SPLIT or mid-RECALL SHALL abandon the operation, and the block SHALL be in LIVE on the first edge after release.

Verification
REQ-032 Reset, RUN=1, DIN=24'h012345, LAP -> next cycle MODE=01, DOUT=24'h012345, LAPNO=1; after 200 EN100HZ MODE=00, DOUT follows DIN.
REQ-033 Five LAPs with DIN = 24'h000100, 000200, 000300, 000400, 000500, then wait, then RECALL x4 -> DOUT 000200, 000300, 000400, 000500 with LAPNO 1..4, FULL=1; fifth RECALL -> MODE=00.
REQ-034 RUN=0, LAP -> MODE stays 00, CNT stays 0; RECALL with CNT=0 -> MODE stays 00.
REQ-035 LAP and RECALL in the same cycle in LIVE with CNT=1 -> SPLIT, CNT=2; CLR and LAP in the same cycle -> LIVE, CNT=0, FULL=0.
REQ-036 In RECALL at LAPNO=2, RUN=1, LAP with DIN=24'h100000 -> SPLIT, DOUT=24'h100000; RST pulsed low mid-SPLIT -> all outputs 0 immediately, MODE=00.

Source files
------------

// File: rtl/lap_memory_if.sv
// Stopwatch lap-memory bus: live time, button pulses and display outputs.
interface lap_memory_if;
  logic        EN100HZ;
  logic        RUN;
  logic        LAP;
  logic        RECALL;
  logic        CLR;
  logic [23:0] DIN;
  logic [23:0] DOUT;
  logic [2:0]  LAPNO;
  logic        FULL;
  logic [1:0]  MODE;

  modport master (
    output EN100HZ, RUN, LAP, RECALL, CLR, DIN,
    input  DOUT, LAPNO, FULL, MODE
  );

  modport slave (
    input  EN100HZ, RUN, LAP, RECALL, CLR, DIN,
    output DOUT, LAPNO, FULL, MODE
  );
endinterface

// File: rtl/lap_memory.sv
// Four-slot circular lap store with split hold and recall browsing.
// Display outputs are registered one cycle behind their cause.
module lap_memory (
  input  logic         CLK,
  input  logic         RST,
  lap_memory_if.slave  bus
);
  typedef enum logic [1:0] {
    LIVE  = 2'b00,
    SPLIT = 2'b01,
    RCL   = 2'b10
  } mode_e;

  mode_e       mode_q, mode_d;
  logic [23:0] mem_q [4];
  logic [23:0] mem_d [4];
  logic [1:0]  wp_q, wp_d;
  logic [1:0]  ri_q, ri_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  lapno_q, lapno_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [23:0] dout_q, dout_d;
  logic        full_q, full_d;
  logic [1:0]  base;
  logic [1:0]  rd_nxt;
  logic        capture;

  always_comb begin
    base    = wp_q - cnt_q[1:0];
    rd_nxt  = base + ri_q + 2'd1;
    capture = bus.LAP && bus.RUN;
    mode_d  = mode_q;
    mem_d   = mem_q;
    wp_d    = wp_q;
    ri_d    = ri_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    dout_d  = dout_q;
    lapno_d = lapno_q;
    if (bus.CLR) begin
      mode_d  = LIVE;
      wp_d    = 2'd0;
      ri_d    = 2'd0;
      cnt_d   = 3'd0;
      tmr_d   = 8'd0;
      dout_d  = bus.DIN;
      lapno_d = 3'd0;
    end else if (capture) begin
      mem_d[wp_q] = bus.DIN;
      wp_d    = wp_q + 2'd1;
      cnt_d   = (cnt_q == 3'd4) ? 3'd4 : cnt_q + 3'd1;
      tmr_d   = 8'd199;
      mode_d  = SPLIT;
      dout_d  = bus.DIN;
      lapno_d = cnt_d;
    end else begin
      unique case (mode_q)
        LIVE: begin
          dout_d  = bus.DIN;
          lapno_d = 3'd0;
          if (bus.RECALL && cnt_q != 3'd0) begin
            mode_d  = RCL;
            ri_d    = 2'd0;
            dout_d  = mem_q[base];
            lapno_d = 3'd1;
          end
        end
        SPLIT: begin
          if (bus.EN100HZ) begin
            if (tmr_q == 8'd0) begin
              mode_d  = LIVE;
              dout_d  = bus.DIN;
              lapno_d = 3'd0;
            end else begin
              tmr_d = tmr_q - 8'd1;
            end
          end
        end
        RCL: begin
          if (bus.RECALL) begin
            if ({1'b0, ri_q} == cnt_q - 3'd1) begin
              mode_d  = LIVE;
              ri_d    = 2'd0;
              dout_d  = bus.DIN;
              lapno_d = 3'd0;
            end else begin
              ri_d    = ri_q + 2'd1;
              dout_d  = mem_q[rd_nxt];
              lapno_d = {1'b0, ri_q} + 3'd2;
            end
          end
        end
        default: mode_d = LIVE;
      endcase
    end
    full_d = (cnt_d == 3'd4);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mode_q  <= LIVE;
      wp_q    <= 2'd0;
      ri_q    <= 2'd0;
      cnt_q   <= 3'd0;
      tmr_q   <= 8'd0;
      dout_q  <= 24'h000000;
      lapno_q <= 3'd0;
      full_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      wp_q    <= wp_d;
      ri_q    <= ri_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      dout_q  <= dout_d;
      lapno_q <= lapno_d;
      full_q  <= full_d;
    end
  end

  // Slot storage needs no reset: CNT gates every read.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign bus.MODE  = mode_q;
  assign bus.DOUT  = dout_q;
  assign bus.LAPNO = lapno_q;
  assign bus.FULL  = full_q;
endmodule

// File: tb/tb_lap_memory.sv
// Bench for lap_memory: queue-based lap model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_lap_memory;
  logic CLK = 1'b0;
  logic RST;
  lap_memory_if bus ();

  lap_memory dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int misses  = 0;

  logic [23:0] laps[$];
  logic [1:0]  m_mode  = 2'd0;
  logic [23:0] m_dout  = 24'h0;
  logic [2:0]  m_lapno = 3'd0;
  int          left    = 0;
  int          pos     = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misses++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               nm, $time, act, exp);
    end
  endtask

  // Reference behaviour: the last four laps in capture order.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      laps.delete();
      m_mode  = 2'd0;
      m_dout  = 24'h0;
      m_lapno = 3'd0;
      left    = 0;
      pos     = 0;
    end else if (bus.CLR) begin
      laps.delete();
      m_mode  = 2'd0;
      m_dout  = bus.DIN;
      m_lapno = 3'd0;
    end else if (bus.LAP && bus.RUN) begin
      laps.push_back(bus.DIN);
      if (laps.size() > 4) laps.delete(0);
      m_mode  = 2'd1;
      m_dout  = bus.DIN;
      m_lapno = 3'(laps.size());
      left    = 200;
    end else if (bus.RECALL && m_mode == 2'd0 && laps.size() > 0) begin
      m_mode  = 2'd2;
      pos     = 0;
      m_dout  = laps[0];
      m_lapno = 3'd1;
    end else if (bus.RECALL && m_mode == 2'd2) begin
      pos++;
      if (pos == laps.size()) begin
        m_mode  = 2'd0;
        m_dout  = bus.DIN;
        m_lapno = 3'd0;
      end else begin
        m_dout  = laps[pos];
        m_lapno = 3'(pos + 1);
      end
    end else if (m_mode == 2'd1) begin
      if (bus.EN100HZ) begin
        left--;
        if (left == 0) begin
          m_mode  = 2'd0;
          m_dout  = bus.DIN;
          m_lapno = 3'd0;
        end
      end
    end else if (m_mode == 2'd0) begin
      m_dout  = bus.DIN;
      m_lapno = 3'd0;
    end
  end

  always @(negedge CLK) begin
    chk("model_mode",  32'(bus.MODE),  32'(m_mode));
    chk("model_dout",  32'(bus.DOUT),  32'(m_dout));
    chk("model_lapno", 32'(bus.LAPNO), 32'(m_lapno));
    chk("model_full",  32'(bus.FULL),  32'(laps.size() == 4));
  end

  task automatic cyc(input logic e, input logic l, input logic r,
                     input logic c, input logic [23:0] d);
    bus.EN100HZ = e;
    bus.LAP     = l;
    bus.RECALL  = r;
    bus.CLR     = c;
    bus.DIN     = d;
    @(posedge CLK);
    #2;
    bus.EN100HZ = 1'b0;
    bus.LAP     = 1'b0;
    bus.RECALL  = 1'b0;
    bus.CLR     = 1'b0;
  endtask

  task automatic ticks(input int n, input logic [23:0] d);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, d);
  endtask

  initial begin
    RST         = 1'b0;
    bus.EN100HZ = 1'b0;
    bus.RUN     = 1'b0;
    bus.LAP     = 1'b0;
    bus.RECALL  = 1'b0;
    bus.CLR     = 1'b0;
    bus.DIN     = 24'h0;
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_mode",  32'(bus.MODE),  32'd0);
    chk("rst_dout",  32'(bus.DOUT),  32'd0);
    chk("rst_lapno", 32'(bus.LAPNO), 32'd0);
    chk("rst_full",  32'(bus.FULL),  32'd0);
    RST = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h000011);
    chk("live_follow", 32'(bus.DOUT), 32'h000011);

    // Single lap and its 200-tick hold
    bus.RUN = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h012345);
    chk("lap1_mode",  32'(bus.MODE),  32'd1);
    chk("lap1_dout",  32'(bus.DOUT),  32'h012345);
    chk("lap1_lapno", 32'(bus.LAPNO), 32'd1);
    ticks(199, 24'h000777);
    chk("hold199_mode", 32'(bus.MODE), 32'd1);
    chk("hold199_dout", 32'(bus.DOUT), 32'h012345);
    ticks(1, 24'h000777);
    chk("hold200_mode", 32'(bus.MODE), 32'd0);
    chk("hold200_dout", 32'(bus.DOUT), 32'h000777);

    // Five laps wrap the buffer; recall walks the newest four
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
    for (int i = 1; i <= 5; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'(i * 256));
    chk("wrap_lapno", 32'(bus.LAPNO), 32'd4);
    chk("wrap_full",  32'(bus.FULL),  32'd1);
    ticks(200, 24'h000999);
    chk("wrap_live", 32'(bus.MODE), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h000999);
    chk("rc1_dout",  32'(bus.DOUT),  32'h000200);
    chk("rc1_lapno", 32'(bus.LAPNO), 32'd1);
    ticks(250, 24'h000999);
    chk("rc_notimeout", 32'(bus.MODE), 32'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h000999);
    chk("rc2_dout", 32'(bus.DOUT), 32'h000300);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h000999);
    chk("rc3_dout", 32'(bus.DOUT), 32'h000400);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h000999);
    chk("rc4_dout",  32'(bus.DOUT),  32'h000500);
    chk("rc4_lapno", 32'(bus.LAPNO), 32'd4);
    chk("rc4_full",  32'(bus.FULL),  32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h000999);
    chk("rc5_mode", 32'(bus.MODE), 32'd0);

    // Ignored LAP with RUN=0 and ignored RECALL with empty store
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
    bus.RUN = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h000042);
    chk("norun_mode", 32'(bus.MODE), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h000043);
    chk("empty_rc_mode", 32'(bus.MODE), 32'd0);
    chk("empty_rc_dout", 32'(bus.DOUT), 32'h000043);
    bus.RUN = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h000044);
    chk("cnt0_lapno", 32'(bus.LAPNO), 32'd1);

    // Coincident pulses
    ticks(200, 24'h000045);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 24'h000046);
    chk("lap_rc_mode",  32'(bus.MODE),  32'd1);
    chk("lap_rc_lapno", 32'(bus.LAPNO), 32'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h000047);
    chk("split_rc_ign", 32'(bus.MODE), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h000048);
    chk("clr_lap_mode",  32'(bus.MODE),  32'd0);
    chk("clr_lap_lapno", 32'(bus.LAPNO), 32'd0);
    chk("clr_lap_full",  32'(bus.FULL),  32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h000049);
    chk("clr_cnt0", 32'(bus.MODE), 32'd0);

    // Lap from RECALL, then reset mid-SPLIT
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h000050);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h000051);
    ticks(200, 24'h000052);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h000052);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h000052);
    chk("rc_l2_lapno", 32'(bus.LAPNO), 32'd2);
    chk("rc_l2_dout",  32'(bus.DOUT),  32'h000051);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h100000);
    chk("rc_lap_mode",  32'(bus.MODE),  32'd1);
    chk("rc_lap_dout",  32'(bus.DOUT),  32'h100000);
    chk("rc_lap_lapno", 32'(bus.LAPNO), 32'd3);
    ticks(5, 24'h000053);
    #1;
    RST = 1'b0;
    #1;
    chk("arst_mode",  32'(bus.MODE),  32'd0);
    chk("arst_dout",  32'(bus.DOUT),  32'd0);
    chk("arst_lapno", 32'(bus.LAPNO), 32'd0);
    chk("arst_full",  32'(bus.FULL),  32'd0);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h000054);
    chk("post_rst_mode", 32'(bus.MODE), 32'd0);
    chk("post_rst_dout", 32'(bus.DOUT), 32'h000054);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h000055);
    chk("post_rst_rc", 32'(bus.MODE), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h000055);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
